// File: rtl/fibonacci_pkg.sv
// Shared constants for the Fibonacci pad driver: widths, pad mapping and FSM encoding.
// No logic; pure declarations.
// No flow control; constants only.
package fibonacci_pkg;

    localparam int CLOCK_WIDTH = 6;
    localparam int VAL_WIDTH   = 30;
    localparam int IO_PADS     = 38;
    localparam int VAL_LSB     = 8;
    localparam int IDX_WIDTH   = 6;

    // Sequence FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WRAP = 2'd2;

    // Largest Fibonacci value that fits VAL_WIDTH bits, and its index
    localparam logic [VAL_WIDTH-1:0] FIB_MAX = 30'd701408733;
    localparam logic [IDX_WIDTH-1:0] IDX_MAX = 6'd44;

endpackage

// File: rtl/fibonacci_if.sv
// Control inputs and pad/status outputs of the Fibonacci core, bundled.
// No logic; wiring only.
// No flow control; level signals sampled every cycle.
interface fibonacci_if;
    import fibonacci_pkg::*;

    logic                   switch_in;
    logic [CLOCK_WIDTH-1:0] clock_sel_in;
    logic [IO_PADS-1:0]     io_out;
    logic [IO_PADS-1:0]     io_oeb;
    logic [IDX_WIDTH-1:0]   idx_o;
    logic                   wrap_o;

    // Driver side: control block / bench
    modport master (
        output switch_in, clock_sel_in,
        input  io_out, io_oeb, idx_o, wrap_o
    );

    // Core side
    modport slave (
        input  switch_in, clock_sel_in,
        output io_out, io_oeb, idx_o, wrap_o
    );
endinterface

// File: rtl/fib_prescaler.sv
// Step-rate divider: one tick every sel cycles while enabled; sel=0 never ticks.
// Tick is combinational from the registered count (same-cycle).
// No backpressure; count is cleared whenever en is low.
module fib_prescaler
    import fibonacci_pkg::*;
(
    input  logic                   wb_clk_i,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [CLOCK_WIDTH-1:0] sel,
    output logic                   tick
);

    localparam logic [CLOCK_WIDTH-1:0] CNT_ONE = 1;

    logic [CLOCK_WIDTH-1:0] div_cnt_q;
    logic [CLOCK_WIDTH-1:0] div_cnt_d;

    // Tick on >= so a shrinking sel below the current count fires next cycle instead of locking up
    always_comb begin
        tick      = en && (sel != '0) && (div_cnt_q >= (sel - CNT_ONE));
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else if (sel != '0) begin
            div_cnt_d = div_cnt_q + CNT_ONE;
        end
    end

    // Count register, synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/fibonacci_core.sv
// Fibonacci generator driving io_out[37:8]; restarts at 0 after the last 30-bit value.
// Value is registered: io_out changes the cycle after the tick edge.
// switch_in=0 pauses immediately (tick on that cycle is dropped); no other backpressure.
module fibonacci_core
    import fibonacci_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       reset_n,
    fibonacci_if.slave bus
);

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [VAL_WIDTH-1:0] VAL_ONE = 1;

    logic [1:0]           state_q, state_d;
    logic                 pending_wrap_q, pending_wrap_d;
    logic [VAL_WIDTH-1:0] cur_q, cur_d;
    logic [VAL_WIDTH-1:0] nxt_q, nxt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 wrap_q, wrap_d;
    logic                 drive_q;
    logic [VAL_WIDTH:0]   sum;
    logic                 tick;
    logic                 pre_en;

    assign pre_en = (state_q == RUN) || (state_q == WRAP);

    fib_prescaler u_prescaler (
        .wb_clk_i (wb_clk_i),
        .reset_n  (reset_n),
        .en       (pre_en),
        .sel      (bus.clock_sel_in),
        .tick     (tick)
    );

    // Sequence FSM and adder; carry out of the adder marks the last representable value
    always_comb begin
        sum            = {1'b0, cur_q} + {1'b0, nxt_q};
        state_d        = state_q;
        pending_wrap_d = pending_wrap_q;
        cur_d          = cur_q;
        nxt_d          = nxt_q;
        idx_d          = idx_q;
        wrap_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.switch_in) begin
                    state_d        = pending_wrap_q ? WRAP : RUN;
                    pending_wrap_d = 1'b0;
                end
            end
            RUN: begin
                if (!bus.switch_in) begin
                    state_d        = IDLE;
                    pending_wrap_d = 1'b0;
                end else if (tick) begin
                    cur_d = nxt_q;
                    idx_d = idx_q + IDX_ONE;
                    if (sum[VAL_WIDTH]) begin
                        state_d = WRAP;
                    end else begin
                        nxt_d = sum[VAL_WIDTH-1:0];
                    end
                end
            end
            WRAP: begin
                if (!bus.switch_in) begin
                    state_d        = IDLE;
                    pending_wrap_d = 1'b1;
                end else if (tick) begin
                    cur_d   = '0;
                    nxt_d   = VAL_ONE;
                    idx_d   = '0;
                    wrap_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; pads go tristate only while reset is held
    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pending_wrap_q <= 1'b0;
            cur_q          <= '0;
            nxt_q          <= VAL_ONE;
            idx_q          <= '0;
            wrap_q         <= 1'b0;
            drive_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_wrap_q <= pending_wrap_d;
            cur_q          <= cur_d;
            nxt_q          <= nxt_d;
            idx_q          <= idx_d;
            wrap_q         <= wrap_d;
            drive_q        <= 1'b1;
        end
    end

    assign bus.io_out = {cur_q, {VAL_LSB{1'b0}}};
    assign bus.io_oeb = drive_q ? {{VAL_WIDTH{1'b0}}, {VAL_LSB{1'b1}}} : {IO_PADS{1'b1}};
    assign bus.idx_o  = idx_q;
    assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_fibonacci_core.sv
// Directed bench for fibonacci_core: reset, step rate, prescale, wrap, pause, mid-run reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_fibonacci_core;
    import fibonacci_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fibonacci_if bus ();

    fibonacci_core dut (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, then release with the given controls; next edge enters RUN
    task automatic restart(input logic [5:0] sel);
        rst_n            = 1'b0;
        bus.switch_in    = 1'b0;
        bus.clock_sel_in = sel;
        cyc();
        cyc();
        rst_n         = 1'b1;
        bus.switch_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.switch_in    = 1'b1;
        bus.clock_sel_in = 6'd1;
        repeat (3) cyc();
        checks++;
        if (bus.io_out !== 38'h0) begin
            errors++; $display("FAIL reset_io_out got %h expected 0", bus.io_out);
        end
        checks++;
        if (bus.io_oeb !== 38'h3F_FFFF_FFFF) begin
            errors++; $display("FAIL reset_io_oeb got %h expected 3fffffffff", bus.io_oeb);
        end
        checks++;
        if (bus.idx_o !== 6'd0) begin
            errors++; $display("FAIL reset_idx got %0d expected 0", bus.idx_o);
        end
        checks++;
        if (bus.wrap_o !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got %b expected 0", bus.wrap_o);
        end
    endtask

    task automatic test_rate1();
        logic [29:0] exp_v [8];
        exp_v = '{30'd0, 30'd1, 30'd1, 30'd2, 30'd3, 30'd5, 30'd8, 30'd13};
        restart(6'd1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (bus.io_out[37:8] !== exp_v[i] || bus.idx_o !== 6'(i)) begin
                errors++;
                $display("FAIL rate1_step%0d got val %0d idx %0d expected val %0d idx %0d",
                         i, bus.io_out[37:8], bus.idx_o, exp_v[i], i);
            end
        end
        checks++;
        if (bus.io_oeb !== {30'h0, 8'hFF}) begin
            errors++; $display("FAIL run_io_oeb got %h expected 00000000ff", bus.io_oeb);
        end
        checks++;
        if (bus.io_out[7:0] !== 8'h00) begin
            errors++; $display("FAIL run_io_out_low got %h expected 00", bus.io_out[7:0]);
        end
    endtask

    task automatic test_prescale();
        logic [5:0] exp_i [5];
        restart(6'd5);
        cyc();  // enter RUN, count starts at 0
        // steps land on the 5th, 10th edge after entering RUN
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (bus.idx_o !== 6'(k / 5)) begin
                errors++;
                $display("FAIL prescale5_edge%0d got idx %0d expected %0d", k, bus.idx_o, k / 5);
            end
        end
        cyc();
        cyc();  // count now 2
        bus.clock_sel_in = 6'd0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (bus.idx_o !== 6'd2 || bus.io_out[37:8] !== 30'd1) begin
                errors++;
                $display("FAIL prescale_hold%0d got idx %0d val %0d expected idx 2 val 1",
                         k, bus.idx_o, bus.io_out[37:8]);
            end
        end
        // count 2 >= 2-1 so the first edge ticks, then every 2nd edge
        bus.clock_sel_in = 6'd2;
        exp_i = '{6'd3, 6'd3, 6'd4, 6'd4, 6'd5};
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (bus.idx_o !== exp_i[k]) begin
                errors++;
                $display("FAIL prescale2_edge%0d got idx %0d expected %0d", k, bus.idx_o, exp_i[k]);
            end
        end
        checks++;
        if (bus.io_out[37:8] !== 30'd5) begin
            errors++; $display("FAIL prescale2_val got %0d expected 5", bus.io_out[37:8]);
        end
    endtask

    task automatic test_wrap();
        logic [29:0] exp_v [4];
        logic        exp_w [4];
        restart(6'd1);
        cyc();                 // RUN, value 0
        repeat (44) cyc();     // 44 steps
        checks++;
        if (bus.io_out[37:8] !== FIB_MAX || bus.idx_o !== IDX_MAX || bus.wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_top got val %0d idx %0d wrap %b expected 701408733 44 0",
                     bus.io_out[37:8], bus.idx_o, bus.wrap_o);
        end
        // pause while in WRAP, then resume: restart must still happen
        bus.switch_in = 1'b0;
        repeat (3) cyc();
        checks++;
        if (bus.io_out[37:8] !== FIB_MAX || bus.idx_o !== IDX_MAX || bus.wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pause got val %0d idx %0d wrap %b expected 701408733 44 0",
                     bus.io_out[37:8], bus.idx_o, bus.wrap_o);
        end
        bus.switch_in = 1'b1;
        cyc();                 // back to WRAP
        checks++;
        if (bus.io_out[37:8] !== FIB_MAX || bus.wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_resume got val %0d wrap %b expected 701408733 0",
                     bus.io_out[37:8], bus.wrap_o);
        end
        exp_v = '{30'd0, 30'd1, 30'd1, 30'd2};
        exp_w = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (bus.io_out[37:8] !== exp_v[k] || bus.idx_o !== 6'(k) || bus.wrap_o !== exp_w[k]) begin
                errors++;
                $display("FAIL wrap_after%0d got val %0d idx %0d wrap %b expected %0d %0d %b",
                         k, bus.io_out[37:8], bus.idx_o, bus.wrap_o, exp_v[k], k, exp_w[k]);
            end
        end
    endtask

    task automatic test_pause();
        restart(6'd1);
        cyc();
        repeat (8) cyc();      // idx 8, value 21
        checks++;
        if (bus.io_out[37:8] !== 30'd21 || bus.idx_o !== 6'd8) begin
            errors++;
            $display("FAIL pause_start got val %0d idx %0d expected 21 8", bus.io_out[37:8], bus.idx_o);
        end
        bus.switch_in = 1'b0;  // tick on this edge is dropped
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if (bus.io_out[37:8] !== 30'd21 || bus.idx_o !== 6'd8 || bus.io_oeb[37:8] !== 30'd0) begin
                errors++;
                $display("FAIL pause_hold%0d got val %0d idx %0d oeb %h expected 21 8 0",
                         k, bus.io_out[37:8], bus.idx_o, bus.io_oeb[37:8]);
            end
        end
        bus.switch_in = 1'b1;
        cyc();                 // IDLE -> RUN
        checks++;
        if (bus.io_out[37:8] !== 30'd21) begin
            errors++; $display("FAIL pause_resume got val %0d expected 21", bus.io_out[37:8]);
        end
        cyc();
        checks++;
        if (bus.io_out[37:8] !== 30'd34 || bus.idx_o !== 6'd9) begin
            errors++;
            $display("FAIL pause_next got val %0d idx %0d expected 34 9", bus.io_out[37:8], bus.idx_o);
        end
    endtask

    task automatic test_reset_midrun();
        logic [29:0] exp_v [3];
        restart(6'd1);
        cyc();
        repeat (30) cyc();     // idx 30
        checks++;
        if (bus.idx_o !== 6'd30 || bus.io_out[37:8] !== 30'd832040) begin
            errors++;
            $display("FAIL midrun_pre got idx %0d val %0d expected 30 832040", bus.idx_o, bus.io_out[37:8]);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if (bus.io_out !== 38'h0 || bus.idx_o !== 6'd0 || bus.io_oeb !== 38'h3F_FFFF_FFFF) begin
            errors++;
            $display("FAIL midrun_reset got io %h idx %0d oeb %h expected 0 0 3fffffffff",
                     bus.io_out, bus.idx_o, bus.io_oeb);
        end
        rst_n = 1'b1;
        exp_v = '{30'd0, 30'd1, 30'd1};
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (bus.io_out[37:8] !== exp_v[k] || bus.idx_o !== 6'(k)) begin
                errors++;
                $display("FAIL midrun_restart%0d got val %0d idx %0d expected %0d %0d",
                         k, bus.io_out[37:8], bus.idx_o, exp_v[k], k);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.switch_in    = 1'b0;
        bus.clock_sel_in = 6'd0;
        #1;
        test_reset();
        test_rate1();
        test_prescale();
        test_wrap();
        test_pause();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
